// File: rtl/iommu_wsi_ig_pkg.sv
// rtl/iommu_wsi_ig_pkg.sv - shared IOMMU interrupt-source indices and sizing
package iommu_wsi_ig_pkg;

    typedef enum logic [1:0] {
        SRC_CQ  = 2'd0,
        SRC_FQ  = 2'd1,
        SRC_HPM = 2'd2,
        SRC_PQ  = 2'd3
    } src_e;

    localparam int N_SRC             = 4;
    localparam int N_INT_VEC_DEFAULT = 16;

endpackage

// File: rtl/iommu_wsi_ig_ipsr_set_ctrl.sv
// rtl/iommu_wsi_ig_ipsr_set_ctrl.sv - per-source ipsr set-request tracking and strobe
module iommu_ipsr_set_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ev_i,
    input  logic en_i,
    input  logic ipsr_i,
    output logic set_o
);

    logic set_pend_q;
    logic set_pend_d;
    logic set_d;

    // Request survives until ipsr reads 1; a strobe already in flight is not
    // repeated back-to-back, but is re-issued if the bit was cleared under it.
    always_comb begin
        set_pend_d = en_i & (ev_i | (set_pend_q & ~ipsr_i));
        set_d      = set_pend_d & ~ipsr_i & ~set_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            set_pend_q <= 1'b0;
            set_o      <= 1'b0;
        end else begin
            set_pend_q <= set_pend_d;
            set_o      <= set_d;
        end
    end

endmodule

// File: rtl/iommu_wsi_ig.sv
// rtl/iommu_wsi_ig.sv - IOMMU wire-signaled interrupt generator
module iommu_wsi_ig
    import iommu_wsi_ig_pkg::*;
#(
    parameter int N_INT_VEC = N_INT_VEC_DEFAULT,
    parameter int VEC_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wsi_en_i,
    input  logic                 cq_ev_i,
    input  logic                 fq_ev_i,
    input  logic                 hpm_ev_i,
    input  logic                 pq_ev_i,
    input  logic                 cie_i,
    input  logic                 fie_i,
    input  logic                 pie_i,
    input  logic                 cip_i,
    input  logic                 fip_i,
    input  logic                 pmip_i,
    input  logic                 pip_i,
    input  logic [VEC_W-1:0]     civ_i,
    input  logic [VEC_W-1:0]     fiv_i,
    input  logic [VEC_W-1:0]     pmiv_i,
    input  logic [VEC_W-1:0]     piv_i,
    output logic [N_SRC-1:0]     ipsr_set_o,
    output logic [N_INT_VEC-1:0] wsi_o
);

    logic [N_SRC-1:0]     ev;
    logic [N_SRC-1:0]     en;
    logic [N_SRC-1:0]     ipsr;
    logic [VEC_W-1:0]     vec [N_SRC];
    logic [N_INT_VEC-1:0] wsi_d;

    always_comb begin
        ev[int'(SRC_CQ)]    = cq_ev_i;
        ev[int'(SRC_FQ)]    = fq_ev_i;
        ev[int'(SRC_HPM)]   = hpm_ev_i;
        ev[int'(SRC_PQ)]    = pq_ev_i;
        en[int'(SRC_CQ)]    = cie_i;
        en[int'(SRC_FQ)]    = fie_i;
        en[int'(SRC_HPM)]   = 1'b1;
        en[int'(SRC_PQ)]    = pie_i;
        ipsr[int'(SRC_CQ)]  = cip_i;
        ipsr[int'(SRC_FQ)]  = fip_i;
        ipsr[int'(SRC_HPM)] = pmip_i;
        ipsr[int'(SRC_PQ)]  = pip_i;
        vec[int'(SRC_CQ)]   = civ_i;
        vec[int'(SRC_FQ)]   = fiv_i;
        vec[int'(SRC_HPM)]  = pmiv_i;
        vec[int'(SRC_PQ)]   = piv_i;
    end

    for (genvar s = 0; s < N_SRC; s++) begin : g_set
        iommu_ipsr_set_ctrl u_set_ctrl (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .ev_i   (ev[s]),
            .en_i   (en[s]),
            .ipsr_i (ipsr[s]),
            .set_o  (ipsr_set_o[s])
        );
    end

    // Out-of-range vectors simply match no line.
    always_comb begin
        wsi_d = '0;
        for (int v = 0; v < N_INT_VEC; v++) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (ipsr[s] && (32'(vec[s]) == v)) begin
                    wsi_d[v] = 1'b1;
                end
            end
        end
        if (!wsi_en_i) begin
            wsi_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wsi_o <= '0;
        end else begin
            wsi_o <= wsi_d;
        end
    end

endmodule

// File: tb/tb_iommu_wsi_ig.sv
// tb/tb_iommu_wsi_ig.sv - self-checking bench for iommu_wsi_ig
module tb_iommu_wsi_ig;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [3:0]  ev;
    logic [3:0]  ie;
    logic [3:0]  ip;
    logic [15:0] vecs;
    logic [3:0]  set16;
    logic [3:0]  set8;
    logic [15:0] wsi16;
    logic [7:0]  wsi8;

    always #5 clk = ~clk;

    iommu_wsi_ig dut16 (
        .clk_i(clk), .rst_i(rst), .wsi_en_i(wen),
        .cq_ev_i(ev[0]), .fq_ev_i(ev[1]), .hpm_ev_i(ev[2]), .pq_ev_i(ev[3]),
        .cie_i(ie[0]), .fie_i(ie[1]), .pie_i(ie[3]),
        .cip_i(ip[0]), .fip_i(ip[1]), .pmip_i(ip[2]), .pip_i(ip[3]),
        .civ_i(vecs[3:0]), .fiv_i(vecs[7:4]), .pmiv_i(vecs[11:8]), .piv_i(vecs[15:12]),
        .ipsr_set_o(set16), .wsi_o(wsi16)
    );

    iommu_wsi_ig #(.N_INT_VEC(8), .VEC_W(4)) dut8 (
        .clk_i(clk), .rst_i(rst), .wsi_en_i(wen),
        .cq_ev_i(ev[0]), .fq_ev_i(ev[1]), .hpm_ev_i(ev[2]), .pq_ev_i(ev[3]),
        .cie_i(ie[0]), .fie_i(ie[1]), .pie_i(ie[3]),
        .cip_i(ip[0]), .fip_i(ip[1]), .pmip_i(ip[2]), .pip_i(ip[3]),
        .civ_i(vecs[3:0]), .fiv_i(vecs[7:4]), .pmiv_i(vecs[11:8]), .piv_i(vecs[15:12]),
        .ipsr_set_o(set8), .wsi_o(wsi8)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        wen;
        logic [3:0]  ev;
        logic [3:0]  ie;
        logic [3:0]  ip;
        logic [15:0] vecs;
        logic [3:0]  eset;
        logic [15:0] ewsi;
        logic [7:0]  ewsi8;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  eset;
        logic [15:0] ewsi;
        logic [7:0]  ewsi8;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input string n, input logic r, input logic w, input logic [3:0] e,
                       input logic [3:0] ie_v, input logic [3:0] ip_v, input logic [15:0] vs,
                       input logic [3:0] es, input logic [15:0] ew, input logic [7:0] ew8);
        vec_t t;
        t.name = n; t.rst = r; t.wen = w; t.ev = e; t.ie = ie_v; t.ip = ip_v;
        t.vecs = vs; t.eset = es; t.ewsi = ew; t.ewsi8 = ew8;
        tbl.push_back(t);
    endtask

    task automatic apply(input vec_t t);
        exp_t x;
        exp_t got;
        rst = t.rst; wen = t.wen; ev = t.ev; ie = t.ie; ip = t.ip; vecs = t.vecs;
        x.name = t.name; x.eset = t.eset; x.ewsi = t.ewsi; x.ewsi8 = t.ewsi8;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", t.name);
        end else begin
            got = sb.pop_front();
            chk({got.name, ".set16"}, 16'(set16), 16'(got.eset));
            chk({got.name, ".set8"},  16'(set8),  16'(got.eset));
            chk({got.name, ".wsi16"}, wsi16,      got.ewsi);
            chk({got.name, ".wsi8"},  16'(wsi8),  16'(got.ewsi8));
        end
    endtask

    initial begin
        logic cip_model;
        logic pend_w;
        int   nstb;

        rst = 1'b1; wen = 1'b0; ev = '0; ie = '0; ip = '0; vecs = '0;

        // name            rst  wen ev    ie    ip    {piv,pmiv,fiv,civ} eset  wsi16     wsi8
        add("rst_ev_lost",  1, 1, 4'hF, 4'hB, 4'h0, 16'h9C53, 4'h0, 16'h0000, 8'h00);
        add("post_rst",     0, 1, 4'h0, 4'hB, 4'h0, 16'h9C53, 4'h0, 16'h0000, 8'h00);
        add("cq_ev",        0, 1, 4'h1, 4'hB, 4'h0, 16'h9C53, 4'h1, 16'h0000, 8'h00);
        add("cq_hold",      0, 1, 4'h0, 4'hB, 4'h0, 16'h9C53, 4'h0, 16'h0000, 8'h00);
        add("cip_civ3",     0, 1, 4'h0, 4'hB, 4'h1, 16'h9C53, 4'h0, 16'h0008, 8'h08);
        add("cq_ev_cip1",   0, 1, 4'h1, 4'hB, 4'h1, 16'h9C53, 4'h0, 16'h0008, 8'h08);
        add("cq_after",     0, 1, 4'h0, 4'hB, 4'h1, 16'h9C53, 4'h0, 16'h0008, 8'h08);
        add("civ_move7",    0, 1, 4'h0, 4'hB, 4'h1, 16'h9C57, 4'h0, 16'h0080, 8'h80);
        add("fip_on",       0, 1, 4'h0, 4'hB, 4'h3, 16'h9C57, 4'h0, 16'h00A0, 8'hA0);
        add("fq_ev_w1c",    0, 1, 4'h2, 4'hB, 4'h3, 16'h9C57, 4'h0, 16'h00A0, 8'hA0);
        add("fip_read0",    0, 1, 4'h0, 4'hB, 4'h1, 16'h9C57, 4'h2, 16'h0080, 8'h80);
        add("fip_inflight", 0, 1, 4'h0, 4'hB, 4'h1, 16'h9C57, 4'h0, 16'h0080, 8'h80);
        add("fip_taken",    0, 1, 4'h0, 4'hB, 4'h3, 16'h9C57, 4'h0, 16'h00A0, 8'hA0);
        add("fip_quiet",    0, 1, 4'h0, 4'hB, 4'h3, 16'h9C57, 4'h0, 16'h00A0, 8'hA0);
        add("shared_vec2",  0, 1, 4'h0, 4'hB, 4'h3, 16'h9C22, 4'h0, 16'h0004, 8'h04);
        add("shared_clrc",  0, 1, 4'h0, 4'hB, 4'h2, 16'h9C22, 4'h0, 16'h0004, 8'h04);
        add("shared_clrf",  0, 1, 4'h0, 4'hB, 4'h0, 16'h9C22, 4'h0, 16'h0000, 8'h00);
        add("pmiv12",       0, 1, 4'h0, 4'hB, 4'h4, 16'h9C22, 4'h0, 16'h1000, 8'h00);
        add("wsi_dis",      0, 0, 4'h0, 4'hB, 4'h1, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("hpm_ev_dis",   0, 0, 4'h4, 4'hB, 4'h1, 16'h9C20, 4'h4, 16'h0000, 8'h00);
        add("hpm_hold",     0, 0, 4'h0, 4'hB, 4'h1, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("wsi_reen",     0, 1, 4'h0, 4'hB, 4'h5, 16'h9C20, 4'h0, 16'h1001, 8'h01);
        add("pq_disabled",  0, 1, 4'h8, 4'h3, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("pq_dis_after", 0, 1, 4'h0, 4'h3, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("pq_ev_pip1",   0, 1, 4'h8, 4'hB, 4'h8, 16'h9C20, 4'h0, 16'h0200, 8'h00);
        add("pie_fall",     0, 1, 4'h0, 4'h3, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("pie_rise",     0, 1, 4'h0, 4'hB, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("fq_pend",      0, 1, 4'h2, 4'hB, 4'h2, 16'h9C20, 4'h0, 16'h0004, 8'h04);
        add("rst_mid",      1, 1, 4'h2, 4'hB, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("rst_after1",   0, 1, 4'h0, 4'hB, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("rst_after2",   0, 1, 4'h0, 4'hB, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("first_ev",     0, 1, 4'h1, 4'hB, 4'h0, 16'h9C20, 4'h1, 16'h0000, 8'h00);
        add("first_hold",   0, 1, 4'h0, 4'hB, 4'h0, 16'h9C20, 4'h0, 16'h0000, 8'h00);
        add("first_taken",  0, 1, 4'h0, 4'hB, 4'h1, 16'h9C20, 4'h0, 16'h0001, 8'h01);
        add("first_quiet",  0, 1, 4'h0, 4'hB, 4'h1, 16'h9C20, 4'h0, 16'h0001, 8'h01);

        foreach (tbl[i]) apply(tbl[i]);

        // Event collides with a W1C of cip; a modelled ipsr register must end up set by one strobe.
        rst = 1'b0; wen = 1'b1; ie = 4'hB; vecs = 16'h9C20;
        cip_model = 1'b1;
        ev = 4'h1; ip = 4'h1;
        @(posedge clk);
        @(negedge clk);
        cip_model = 1'b0;
        ev = 4'h0;
        pend_w = 1'b0;
        nstb = 0;
        for (int i = 0; i < 8; i++) begin
            ip = {3'b000, cip_model};
            @(posedge clk);
            @(negedge clk);
            cip_model = cip_model | pend_w;
            pend_w = set16[0];
            if (set16[0]) nstb++;
        end
        chk("w1c_strobe_count", 16'(nstb), 16'd1);
        chk("w1c_cip_final", 16'(cip_model), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
